// File: rtl/cpu_pkg.sv
// Shared pipeline types and widths used by fetch and later pipeline latches.
package cpu_pkg;

  localparam int unsigned PC_W       = 12;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 27;

  localparam logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE_DEF = 5'b11111;
  localparam logic [INST_W-1:0]              NOP_WORD_DEF    = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Write-enabled register with asynchronous active-low reset to a fixed value.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned  W         = PC_W,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= RESET_VAL;
    end else if (we_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the sync ROM address and feeds the F/D latch.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0]                 RESET_PC    = 12'd0,
  parameter logic [OPCODE_MSB-OPCODE_LSB:0]  HALT_OPCODE = HALT_OPCODE_DEF,
  parameter logic [INST_W-1:0]               NOP_WORD    = NOP_WORD_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirectValid,
  input  logic [PC_W-1:0]   redirectTarget,
  output logic [PC_W-1:0]   imemAddr,
  input  logic [INST_W-1:0] imemData,
  output logic [INST_W-1:0] instOut,
  output logic [PC_W-1:0]   seqNextPcOut,
  output logic              fdEnable,
  output logic              validOut,
  output logic              halted,
  output logic [31:0]       fetchCount
);

  localparam logic [PC_W-1:0] PC_ONE = 1;

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     fetch_count_q, fetch_count_d;

  pc_reg #(
    .W         (PC_W),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk_i  (clock),
    .rst_ni (reset),
    .we_i   (fdEnable),
    .d_i    (pc_d),
    .q_o    (pc_q)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= BOOT;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Every path that moves the PC also raises fdEnable, so fdEnable doubles as the PC write enable.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instOut  = NOP_WORD;
    validOut = 1'b0;
    fdEnable = 1'b1;
    halted   = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirectValid) begin
          pc_d = redirectTarget;
        end else begin
          instOut  = imemData;
          validOut = 1'b1;
          if (stall) begin
            fdEnable = 1'b0;
          end else begin
            pc_d = pc_q + PC_ONE;
            if (imemData[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) begin
              state_d = HALTED;
            end
          end
        end
      end
      HALTED: begin
        halted = 1'b1;
        if (redirectValid) begin
          pc_d    = redirectTarget;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (validOut && fdEnable) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  assign imemAddr     = pc_d;
  assign seqNextPcOut = pc_q + PC_ONE;
  assign fetchCount   = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage with a behavioural synchronous ROM and an expected-output queue.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirectValid = 1'b0;
  logic [11:0] redirectTarget = '0;
  logic [11:0] imemAddr;
  logic [31:0] imemData;
  logic [31:0] instOut;
  logic [11:0] seqNextPcOut;
  logic        fdEnable;
  logic        validOut;
  logic        halted;
  logic [31:0] fetchCount;

  localparam logic [31:0] HALTW = 32'hF800_000A;

  fetch_stage #(
    .RESET_PC    (12'd0),
    .HALT_OPCODE (5'b11111),
    .NOP_WORD    (32'h0000_0000)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirectValid  (redirectValid),
    .redirectTarget (redirectTarget),
    .imemAddr       (imemAddr),
    .imemData       (imemData),
    .instOut        (instOut),
    .seqNextPcOut   (seqNextPcOut),
    .fdEnable       (fdEnable),
    .validOut       (validOut),
    .halted         (halted),
    .fetchCount     (fetchCount)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [4096];
  always @(posedge clock) imemData <= mem[imemAddr];

  // Packed view: {inst, valid, fdEnable, halted, seqNextPc, imemAddr}
  typedef logic [58:0] obs_t;
  obs_t obs;
  assign obs = {instOut, validOut, fdEnable, halted, seqNextPcOut, imemAddr};

  obs_t exp_q[$];
  obs_t want;
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  function automatic obs_t mk(input logic [31:0] i, input logic v, input logic f,
                              input logic h, input logic [11:0] s, input logic [11:0] a);
    return {i, v, f, h, s, a};
  endfunction

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; redirectValid = 1'b0;
    #2;
    exp_q.push_back(mk(32'h0, 1'b0, 1'b1, 1'b0, 12'd1, 12'd0));
    want = exp_q.pop_front(); n_chk++;
    if (obs !== want) $display("FAIL reset_outputs got=%h want=%h", obs, want); else n_pass++;
    n_chk++;
    if (fetchCount !== 32'd0) $display("FAIL reset_count got=%0d want=0", fetchCount); else n_pass++;
    @(negedge clock); reset = 1'b1; #1;
    exp_q.push_back(mk(32'h0, 1'b0, 1'b1, 1'b0, 12'd1, 12'd0));
    want = exp_q.pop_front(); n_chk++;
    if (obs !== want) $display("FAIL boot_bubble got=%h want=%h", obs, want); else n_pass++;
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 4; k++) exp_q.push_back(mk(32'(k), 1'b1, 1'b1, 1'b0, 12'(k), 12'(k)));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      want = exp_q.pop_front(); n_chk++;
      if (obs !== want) $display("FAIL seq_fetch%0d got=%h want=%h", k, obs, want); else n_pass++;
    end
    @(posedge clock); #1;
    n_chk++;
    if (fetchCount !== 32'd4) $display("FAIL seq_count got=%0d want=4", fetchCount); else n_pass++;
  endtask

  task automatic test_stall();
    exp_q.push_back(mk(32'd5, 1'b1, 1'b1, 1'b0, 12'd5, 12'd5));
    @(negedge clock);
    want = exp_q.pop_front(); n_chk++;
    if (obs !== want) $display("FAIL pre_stall got=%h want=%h", obs, want); else n_pass++;
    @(posedge clock); #1;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(mk(32'd6, 1'b1, 1'b0, 1'b0, 12'd6, 12'd5));
      @(negedge clock);
      want = exp_q.pop_front(); n_chk++;
      if (obs !== want) $display("FAIL stall_hold%0d got=%h want=%h", c, obs, want); else n_pass++;
      n_chk++;
      if (fetchCount !== 32'd5) $display("FAIL stall_count got=%0d want=5", fetchCount); else n_pass++;
      @(posedge clock); #1;
    end
    stall = 1'b0;
    exp_q.push_back(mk(32'd6, 1'b1, 1'b1, 1'b0, 12'd6, 12'd6));
    exp_q.push_back(mk(32'd7, 1'b1, 1'b1, 1'b0, 12'd7, 12'd7));
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      want = exp_q.pop_front(); n_chk++;
      if (obs !== want) $display("FAIL stall_release%0d got=%h want=%h", c, obs, want); else n_pass++;
      @(posedge clock); #1;
    end
    n_chk++;
    if (fetchCount !== 32'd7) $display("FAIL post_stall_count got=%0d want=7", fetchCount); else n_pass++;
  endtask

  task automatic test_redirect();
    stall = 1'b1; redirectValid = 1'b1; redirectTarget = 12'h100;
    exp_q.push_back(mk(32'h0, 1'b0, 1'b1, 1'b0, 12'd8, 12'h100));
    @(negedge clock);
    want = exp_q.pop_front(); n_chk++;
    if (obs !== want) $display("FAIL redirect_squash got=%h want=%h", obs, want); else n_pass++;
    @(posedge clock); #1;
    stall = 1'b0; redirectValid = 1'b0;
    exp_q.push_back(mk(32'h101, 1'b1, 1'b1, 1'b0, 12'h101, 12'h101));
    @(negedge clock);
    want = exp_q.pop_front(); n_chk++;
    if (obs !== want) $display("FAIL redirect_target got=%h want=%h", obs, want); else n_pass++;
    n_chk++;
    if (fetchCount !== 32'd7) $display("FAIL redirect_count got=%0d want=7", fetchCount); else n_pass++;
    @(posedge clock); #1;
  endtask

  task automatic test_halt();
    redirectValid = 1'b1; redirectTarget = 12'd9;
    exp_q.push_back(mk(32'h0, 1'b0, 1'b1, 1'b0, 12'h102, 12'd9));
    @(negedge clock);
    want = exp_q.pop_front(); n_chk++;
    if (obs !== want) $display("FAIL halt_redirect got=%h want=%h", obs, want); else n_pass++;
    @(posedge clock); #1;
    redirectValid = 1'b0; stall = 1'b1;
    exp_q.push_back(mk(HALTW, 1'b1, 1'b0, 1'b0, 12'd10, 12'd9));
    @(negedge clock);
    want = exp_q.pop_front(); n_chk++;
    if (obs !== want) $display("FAIL halt_stalled got=%h want=%h", obs, want); else n_pass++;
    @(posedge clock); #1;
    stall = 1'b0;
    exp_q.push_back(mk(HALTW, 1'b1, 1'b1, 1'b0, 12'd10, 12'd10));
    @(negedge clock);
    want = exp_q.pop_front(); n_chk++;
    if (obs !== want) $display("FAIL halt_accept got=%h want=%h", obs, want); else n_pass++;
    @(posedge clock); #1;
    for (int c = 0; c < 20; c++) begin
      stall = c[0];
      exp_q.push_back(mk(32'h0, 1'b0, 1'b1, 1'b1, 12'd11, 12'd10));
      @(negedge clock);
      want = exp_q.pop_front(); n_chk++;
      if (obs !== want) $display("FAIL halted%0d got=%h want=%h", c, obs, want); else n_pass++;
      n_chk++;
      if (fetchCount !== 32'd9) $display("FAIL halted_count got=%0d want=9", fetchCount); else n_pass++;
      @(posedge clock); #1;
    end
    stall = 1'b0; redirectValid = 1'b1; redirectTarget = 12'd3;
    exp_q.push_back(mk(32'h0, 1'b0, 1'b1, 1'b1, 12'd11, 12'd3));
    @(negedge clock);
    want = exp_q.pop_front(); n_chk++;
    if (obs !== want) $display("FAIL halt_exit got=%h want=%h", obs, want); else n_pass++;
    @(posedge clock); #1;
    redirectValid = 1'b0;
    exp_q.push_back(mk(32'd4, 1'b1, 1'b1, 1'b0, 12'd4, 12'd4));
    @(negedge clock);
    want = exp_q.pop_front(); n_chk++;
    if (obs !== want) $display("FAIL halt_resume got=%h want=%h", obs, want); else n_pass++;
    @(posedge clock); #1;
  endtask

  task automatic test_wrap();
    redirectValid = 1'b1; redirectTarget = 12'hFFF;
    exp_q.push_back(mk(32'h0, 1'b0, 1'b1, 1'b0, 12'd5, 12'hFFF));
    @(negedge clock);
    want = exp_q.pop_front(); n_chk++;
    if (obs !== want) $display("FAIL wrap_redirect got=%h want=%h", obs, want); else n_pass++;
    @(posedge clock); #1;
    redirectValid = 1'b0;
    exp_q.push_back(mk(32'h1000, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0));
    exp_q.push_back(mk(32'h1, 1'b1, 1'b1, 1'b0, 12'd1, 12'd1));
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      want = exp_q.pop_front(); n_chk++;
      if (obs !== want) $display("FAIL pc_wrap%0d got=%h want=%h", c, obs, want); else n_pass++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_async_reset();
    redirectValid = 1'b1; redirectTarget = 12'd50;
    exp_q.push_back(mk(32'h0, 1'b0, 1'b1, 1'b0, 12'd2, 12'd50));
    @(negedge clock);
    want = exp_q.pop_front(); n_chk++;
    if (obs !== want) $display("FAIL ar_redirect got=%h want=%h", obs, want); else n_pass++;
    @(posedge clock); #1;
    redirectValid = 1'b0;
    #2;
    exp_q.push_back(mk(32'd51, 1'b1, 1'b1, 1'b0, 12'd51, 12'd51));
    want = exp_q.pop_front(); n_chk++;
    if (obs !== want) $display("FAIL ar_pc50 got=%h want=%h", obs, want); else n_pass++;
    reset = 1'b0; #1;
    exp_q.push_back(mk(32'h0, 1'b0, 1'b1, 1'b0, 12'd1, 12'd0));
    want = exp_q.pop_front(); n_chk++;
    if (obs !== want) $display("FAIL ar_immediate got=%h want=%h", obs, want); else n_pass++;
    n_chk++;
    if (fetchCount !== 32'd0) $display("FAIL ar_count got=%0d want=0", fetchCount); else n_pass++;
    @(negedge clock); reset = 1'b1; #1;
    exp_q.push_back(mk(32'h0, 1'b0, 1'b1, 1'b0, 12'd1, 12'd0));
    exp_q.push_back(mk(32'h1, 1'b1, 1'b1, 1'b0, 12'd1, 12'd1));
    want = exp_q.pop_front(); n_chk++;
    if (obs !== want) $display("FAIL ar_boot got=%h want=%h", obs, want); else n_pass++;
    @(negedge clock);
    want = exp_q.pop_front(); n_chk++;
    if (obs !== want) $display("FAIL ar_first got=%h want=%h", obs, want); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i + 1);
    mem[9] = HALTW;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
